crc_rx_sequencer: RTL and testbench

CRC_RX_SEQUENCER -- requirements
Module: crc_rx_sequencer

---
 rtl/crc_rx_sequencer.sv | 157 +++++++++++++++
 tb/tb_crc_rx_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_rx_sequencer.sv
// Receive-side CRC-15 sequencer: accumulates the frame CRC, captures the CRC field and checks the delimiter.
// Optional build macro CRC_ERR_COUNT_EN adds a saturating CRC-error counter output (crc_err_count).
module crc_rx_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        rx_bit_valid,
    input  logic        rx_bit,
    input  logic        frame_start,
    input  logic        crc_field_start,
    input  logic        frame_abort,
    output logic        busy,
    output logic [14:0] calculated_crc,
    output logic [14:0] received_crc,
    output logic        crc_done,
    output logic        crc_error,
    output logic        delim_error,
    output logic        ack_req,
`ifdef CRC_ERR_COUNT_EN
    output logic [7:0]  crc_err_count,
`endif
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        RECV  = 2'd2,
        DELIM = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  bit_cnt;
    logic        do_clear;
    logic        do_start;
    logic        do_calc;
    logic        do_freeze;
    logic        do_recv;
    logic        do_eval;
    logic        crc_mismatch;

    function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
        crc_step = {crc[13:0], 1'b0} ^ ((b ^ crc[14]) ? 15'h4599 : 15'h0000);
    endfunction

    assign busy         = (state != IDLE);
    assign state_dbg    = state;
    assign crc_mismatch = (calculated_crc != received_crc);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority: enable low, then abort, then a qualified SOF, then per-state bit handling.
    always_comb begin
        state_nxt = state;
        do_clear  = 1'b0;
        do_start  = 1'b0;
        do_calc   = 1'b0;
        do_freeze = 1'b0;
        do_recv   = 1'b0;
        do_eval   = 1'b0;
        if (!enable || frame_abort) begin
            state_nxt = IDLE;
            do_clear  = 1'b1;
        end else if (frame_start && rx_bit_valid) begin
            state_nxt = CALC;
            do_start  = 1'b1;
        end else if (rx_bit_valid) begin
            case (state)
                CALC: begin
                    if (crc_field_start) begin
                        state_nxt = RECV;
                        do_freeze = 1'b1;
                    end else begin
                        do_calc = 1'b1;
                    end
                end
                RECV: begin
                    do_recv = 1'b1;
                    if (bit_cnt == 4'd14) begin
                        state_nxt = DELIM;
                    end
                end
                DELIM: begin
                    do_eval   = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            calculated_crc <= 15'h0000;
            received_crc   <= 15'h0000;
            bit_cnt        <= 4'd0;
            crc_done       <= 1'b0;
            crc_error      <= 1'b0;
            delim_error    <= 1'b0;
            ack_req        <= 1'b0;
        end else begin
            crc_done <= 1'b0;
            ack_req  <= 1'b0;
            if (do_clear) begin
                crc_error   <= 1'b0;
                delim_error <= 1'b0;
                bit_cnt     <= 4'd0;
            end
            // The SOF bit itself is part of the protected sequence, so it is folded in from a zero seed.
            if (do_start) begin
                calculated_crc <= crc_step(15'h0000, rx_bit);
                received_crc   <= 15'h0000;
                crc_error      <= 1'b0;
                delim_error    <= 1'b0;
                bit_cnt        <= 4'd0;
            end
            if (do_calc) begin
                calculated_crc <= crc_step(calculated_crc, rx_bit);
            end
            if (do_freeze) begin
                received_crc <= {received_crc[13:0], rx_bit};
                bit_cnt      <= 4'd1;
            end
            if (do_recv) begin
                received_crc <= {received_crc[13:0], rx_bit};
                bit_cnt      <= bit_cnt + 4'd1;
            end
            if (do_eval) begin
                crc_done    <= 1'b1;
                crc_error   <= crc_mismatch;
                delim_error <= ~rx_bit;
                ack_req     <= ~crc_mismatch & rx_bit;
                bit_cnt     <= 4'd0;
            end
        end
    end

`ifdef CRC_ERR_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_err_count <= 8'd0;
        end else if (do_eval && crc_mismatch && (crc_err_count != 8'd255)) begin
            crc_err_count <= crc_err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crc_rx_sequencer.sv
// Directed bench for crc_rx_sequencer: frame drivers push expected delimiter results, a monitor pops and compares.
// Exercises the CRC_ERR_COUNT_EN counter only when that macro is defined.
module tb_crc_rx_sequencer;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        rx_bit_valid;
    logic        rx_bit;
    logic        frame_start;
    logic        crc_field_start;
    logic        frame_abort;
    logic        busy;
    logic [14:0] calculated_crc;
    logic [14:0] received_crc;
    logic        crc_done;
    logic        crc_error;
    logic        delim_error;
    logic        ack_req;
    logic [1:0]  state_dbg;
`ifdef CRC_ERR_COUNT_EN
    logic [7:0]  crc_err_count;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Expected result per frame: {calculated_crc, received_crc, crc_error, delim_error, ack_req}
    logic [32:0] exp_q[$];

    crc_rx_sequencer dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable          (enable),
        .rx_bit_valid    (rx_bit_valid),
        .rx_bit          (rx_bit),
        .frame_start     (frame_start),
        .crc_field_start (crc_field_start),
        .frame_abort     (frame_abort),
        .busy            (busy),
        .calculated_crc  (calculated_crc),
        .received_crc    (received_crc),
        .crc_done        (crc_done),
        .crc_error       (crc_error),
        .delim_error     (delim_error),
        .ack_req         (ack_req),
`ifdef CRC_ERR_COUNT_EN
        .crc_err_count   (crc_err_count),
`endif
        .state_dbg       (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
        check({tag, "_calc"},  {17'd0, calculated_crc}, 32'd0);
        check({tag, "_recv"},  {17'd0, received_crc}, 32'd0);
        check({tag, "_done"},  {31'd0, crc_done}, 32'd0);
        check({tag, "_err"},   {31'd0, crc_error}, 32'd0);
        check({tag, "_derr"},  {31'd0, delim_error}, 32'd0);
        check({tag, "_ack"},   {31'd0, ack_req}, 32'd0);
    endtask

    // Monitor: every crc_done must match the oldest outstanding frame expectation.
    always @(negedge clock) begin
        if (reset_n && crc_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_crc_done", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("sb_calc",  {17'd0, calculated_crc}, {17'd0, e[32:18]});
                check("sb_recv",  {17'd0, received_crc},   {17'd0, e[17:3]});
                check("sb_err",   {31'd0, crc_error},      {31'd0, e[2]});
                check("sb_derr",  {31'd0, delim_error},    {31'd0, e[1]});
                check("sb_ack",   {31'd0, ack_req},        {31'd0, e[0]});
            end
        end
        if (reset_n && ack_req && !crc_done) begin
            check("ack_without_done", 32'd1, 32'd0);
        end
    end

    // ---------------- drivers ----------------
    task automatic idle_gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_bit(input logic b, input logic fs, input logic cfs);
        rx_bit_valid    = 1'b1;
        rx_bit          = b;
        frame_start     = fs;
        crc_field_start = cfs;
        @(negedge clock);
        rx_bit_valid    = 1'b0;
        frame_start     = 1'b0;
        crc_field_start = 1'b0;
        idle_gap();
    endtask

    task automatic send_head(input logic sof, input logic [7:0] data, input int ndata);
        drive_bit(sof, 1'b1, 1'b0);
        for (int i = ndata - 1; i >= 0; i--) drive_bit(data[i], 1'b0, 1'b0);
    endtask

    task automatic send_crc_bits(input logic [14:0] field, input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(field[14 - i], 1'b0, (i == 0));
    endtask

    task automatic send_frame(input logic sof, input logic [7:0] data, input int ndata,
                              input logic [14:0] field, input logic delim,
                              input logic [14:0] exp_calc, input logic exp_err,
                              input logic exp_derr, input logic exp_ack);
        exp_q.push_back({exp_calc, field, exp_err, exp_derr, exp_ack});
        send_head(sof, data, ndata);
        send_crc_bits(field, 15);
        drive_bit(delim, 1'b0, 1'b0);
    endtask

    task automatic pulse_abort();
        frame_abort = 1'b1;
        @(negedge clock);
        frame_abort = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n         = 1'b0;
        enable          = 1'b1;
        rx_bit_valid    = 1'b0;
        rx_bit          = 1'b0;
        frame_start     = 1'b0;
        crc_field_start = 1'b0;
        frame_abort     = 1'b0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
`ifdef CRC_ERR_COUNT_EN
        check("reset_err_count", {24'd0, crc_err_count}, 32'd0);
`endif
        reset_n = 1'b1;
        @(negedge clock);

        // All-zero frame and all-zero CRC field.
        send_frame(1'b0, 8'h00, 0, 15'h0000, 1'b1, 15'h0000, 1'b0, 1'b0, 1'b1);
        check("idle_after_frame_busy", {31'd0, busy}, 32'd0);

        // One data bit 1 gives the polynomial itself.
        send_frame(1'b0, 8'h01, 1, 15'h4599, 1'b1, 15'h4599, 1'b0, 1'b0, 1'b1);

        // Wrong CRC field: error flagged and held.
        send_frame(1'b0, 8'h01, 1, 15'h4598, 1'b1, 15'h4599, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
        check("crc_err_held", {31'd0, crc_error}, 32'd1);
        drive_bit(1'b0, 1'b1, 1'b0);
        check("crc_err_cleared_by_sof", {31'd0, crc_error}, 32'd0);
        check("busy_after_sof", {31'd0, busy}, 32'd1);
        pulse_abort();
        check("busy_after_abort", {31'd0, busy}, 32'd0);

        // Good CRC, dominant delimiter.
        send_frame(1'b0, 8'h01, 1, 15'h4599, 1'b0, 15'h4599, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        check("delim_err_held", {31'd0, delim_error}, 32'd1);
        pulse_abort();
        check("delim_err_cleared_by_abort", {31'd0, delim_error}, 32'd0);

        // Multi-bit data: hand-derived CRCs 0x0B32 (data 1,1) and 0x4EAB (data 1,0); SOF=1 alone gives 0x4599.
        send_frame(1'b0, 8'h03, 2, 15'h0B32, 1'b1, 15'h0B32, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h02, 2, 15'h4EAB, 1'b1, 15'h4EAB, 1'b0, 1'b0, 1'b1);
        send_frame(1'b1, 8'h00, 0, 15'h4599, 1'b1, 15'h4599, 1'b0, 1'b0, 1'b1);

        // Abort after 7 CRC bits, presented together with a qualified SOF (abort wins).
        send_head(1'b0, 8'h01, 1);
        send_crc_bits(15'h4599, 7);
        check("recv_busy_mid_field", {31'd0, busy}, 32'd1);
        frame_abort  = 1'b1;
        frame_start  = 1'b1;
        rx_bit_valid = 1'b1;
        rx_bit       = 1'b0;
        @(negedge clock);
        frame_abort  = 1'b0;
        frame_start  = 1'b0;
        rx_bit_valid = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_recv_hold", {17'd0, received_crc}, 32'h0045);
        check("abort_calc_hold", {17'd0, calculated_crc}, 32'h4599);
        for (int i = 0; i < 10; i++) drive_bit(1'b1, 1'b0, 1'b0);
        check("idle_ignores_bits", {31'd0, busy}, 32'd0);

        // Enable low overrides a qualified SOF and clears the held error; CRC registers hold.
        send_frame(1'b0, 8'h01, 1, 15'h4598, 1'b1, 15'h4599, 1'b1, 1'b0, 1'b0);
        enable       = 1'b0;
        frame_start  = 1'b1;
        rx_bit_valid = 1'b1;
        rx_bit       = 1'b0;
        @(negedge clock);
        frame_start  = 1'b0;
        rx_bit_valid = 1'b0;
        check("disable_busy", {31'd0, busy}, 32'd0);
        check("disable_err_clear", {31'd0, crc_error}, 32'd0);
        check("disable_calc_hold", {17'd0, calculated_crc}, 32'h4599);
        check("disable_recv_hold", {17'd0, received_crc}, 32'h4598);
        enable = 1'b1;
        @(negedge clock);

        // crc_field_start outside CALC does nothing.
        drive_bit(1'b1, 1'b0, 1'b1);
        check("cfs_in_idle_busy", {31'd0, busy}, 32'd0);
        check("cfs_in_idle_recv", {17'd0, received_crc}, 32'h4598);

        // Asynchronous reset in the middle of RECV.
        send_head(1'b0, 8'h01, 1);
        send_crc_bits(15'h4599, 5);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        send_frame(1'b0, 8'h01, 1, 15'h4599, 1'b1, 15'h4599, 1'b0, 1'b0, 1'b1);

`ifdef CRC_ERR_COUNT_EN
        for (int f = 0; f < 300; f++) begin
            send_frame(1'b0, 8'h01, 1, 15'h4598, 1'b1, 15'h4599, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clock);
        check("err_count_saturated", {24'd0, crc_err_count}, 32'd255);
`endif

        begin
            int waited;
            waited = 0;
            while (exp_q.size() != 0 && waited < 50) begin
                @(negedge clock);
                waited++;
            end
            check("scoreboard_drained", exp_q.size(), 32'd0);
        end
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
